// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS-subset control unit:
//             FSM states, opcode/funct values, ALU/NPC/GPR/WD select codes
//             and the instruction classes produced by the decoder.
//  Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

  // FSM state encodings (visible on the debug state port)
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type functs, instr[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd8;

  // Next-PC select
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  // Register-file write address select
  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_R31 = 2'd2;

  // Register-file write data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Instruction classes; each class follows one path through the FSM
  typedef enum logic [3:0] {
    CL_RALU = 4'd0,   // R-type ALU incl. shifts -> EXEC, WB
    CL_JR   = 4'd1,   // jr  -> EXEC
    CL_IALU = 4'd2,   // addi/ori/lui -> EXEC, WB
    CL_LW   = 4'd3,   // lw  -> EXEC, MEM, WB
    CL_SW   = 4'd4,   // sw  -> EXEC, MEM
    CL_BEQ  = 4'd5,   // beq -> EXEC
    CL_J    = 4'd6,   // j   -> done in DECODE
    CL_JAL  = 4'd7,   // jal -> done in DECODE
    CL_ILL  = 4'd15   // anything undecodable
  } iclass_e;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Combinational instruction decoder. Maps Op/Funct to an
//             instruction class plus the ALU settings used in EXEC and WB.
//  Revision : 1.0  initial release
// ============================================================================
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic [3:0] alu_op_o,
  output logic       alu_src_o,
  output logic       aa_sel_o,
  output logic       ext_op_o,
  output logic       legal_o
);

  // Class and ALU-control lookup; funct only matters for R-type
  always_comb begin
    cls_o     = CL_ILL;
    alu_op_o  = ALU_NOP;
    alu_src_o = 1'b0;
    aa_sel_o  = 1'b0;
    ext_op_o  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: begin cls_o = CL_RALU; alu_op_o = ALU_ADD; end
          FN_SUBU: begin cls_o = CL_RALU; alu_op_o = ALU_SUB; end
          FN_AND:  begin cls_o = CL_RALU; alu_op_o = ALU_AND; end
          FN_OR:   begin cls_o = CL_RALU; alu_op_o = ALU_OR;  end
          FN_SLT:  begin cls_o = CL_RALU; alu_op_o = ALU_SLT; end
          FN_SLL:  begin cls_o = CL_RALU; alu_op_o = ALU_SLL; aa_sel_o = 1'b1; end
          FN_SRL:  begin cls_o = CL_RALU; alu_op_o = ALU_SRL; aa_sel_o = 1'b1; end
          FN_JR:   begin cls_o = CL_JR; end
          default: begin cls_o = CL_ILL; end
        endcase
      end
      OP_ADDI: begin cls_o = CL_IALU; alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
      OP_ORI:  begin cls_o = CL_IALU; alu_op_o = ALU_OR;  alu_src_o = 1'b1; end
      OP_LUI:  begin cls_o = CL_IALU; alu_op_o = ALU_LUI; alu_src_o = 1'b1; end
      OP_LW:   begin cls_o = CL_LW;   alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
      OP_SW:   begin cls_o = CL_SW;   alu_op_o = ALU_ADD; alu_src_o = 1'b1; ext_op_o = 1'b1; end
      OP_BEQ:  begin cls_o = CL_BEQ;  alu_op_o = ALU_SUB; end
      OP_J:    begin cls_o = CL_J;   end
      OP_JAL:  begin cls_o = CL_JAL; end
      default: begin cls_o = CL_ILL; end
    endcase
  end

  assign legal_o = (cls_o != CL_ILL);

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle control FSM for the shared-memory MIPS-subset
//             datapath: FETCH/DECODE/EXEC/MEM/WB with a memory-ready
//             handshake on every memory access.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic       ALUSrc,
  output logic       AASel,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  iclass_e    dec_cls;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src, dec_aa_sel, dec_ext_op, dec_legal;

  mc_decode u_decode (
    .op_i      (Op),
    .funct_i   (Funct),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .aa_sel_o  (dec_aa_sel),
    .ext_op_o  (dec_ext_op),
    .legal_o   (dec_legal)
  );

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and control outputs; reset forces every output low
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = NPC_PC4;
    ALUSrc     = 1'b0;
    AASel      = 1'b0;
    GPRSel     = GPR_RD;
    WDSel      = WD_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
        end else if (dec_cls == CL_J || dec_cls == CL_JAL) begin
          PCWrite    = 1'b1;
          NPCOp      = NPC_JUMP;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
          if (dec_cls == CL_JAL) begin
            // PC already holds old PC+4 here; it is the link value
            RegWrite = 1'b1;
            GPRSel   = GPR_R31;
            WDSel    = WD_PC;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        ALUOp  = dec_alu_op;
        ALUSrc = dec_alu_src;
        AASel  = dec_aa_sel;
        EXTOp  = dec_ext_op;
        case (dec_cls)
          CL_BEQ: begin
            PCWrite    = Zero;
            NPCOp      = NPC_BRANCH;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CL_JR: begin
            PCWrite    = 1'b1;
            NPCOp      = NPC_JR;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CL_LW, CL_SW:     state_d = ST_MEM;
          CL_RALU, CL_IALU: state_d = ST_WB;
          default:          state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        // Address comes from the aluout register; request held until ready
        IorD = 1'b1;
        if (dec_cls == CL_SW) begin
          MemWrite = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end else if (dec_cls == CL_LW) begin
          MemRead = 1'b1;
          if (mem_ready) state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
        ALUOp      = dec_alu_op;
        ALUSrc     = dec_alu_src;
        AASel      = dec_aa_sel;
        EXTOp      = dec_ext_op;
        if (dec_cls == CL_LW) begin
          GPRSel = GPR_RT;
          WDSel  = WD_MEM;
        end else if (dec_cls == CL_IALU) begin
          GPRSel = GPR_RT;
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase

    if (rst) begin
      state_d    = ST_FETCH;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = ALU_NOP;
      NPCOp      = NPC_PC4;
      ALUSrc     = 1'b0;
      AASel      = 1'b0;
      GPRSel     = GPR_RD;
      WDSel      = WD_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl. Two instances share inputs:
//             u_dut0 (ILLEGAL_TRAP=0) and u_dut1 (ILLEGAL_TRAP=1). Expected
//             state traces and write counts come from per-class cycle rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JR = 5, K_J = 6, K_JAL = 7;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, iord, mrd, mwr, rw, ext;
    logic [3:0] alu;
    logic [1:0] npc;
    logic src, aa;
    logic [1:0] gpr, wd;
    logic done, ill;
  } obs_t;

  typedef struct {
    string name; logic [5:0] op; logic [5:0] fn; int kind;
    logic [3:0] alu; logic src; logic aa; logic ext;
  } ent_t;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] Op = 6'd0, Funct = 6'd0;

  logic [2:0] st0, st1;
  logic pcw0, irw0, iord0, mrd0, mwr0, rw0, ext0, src0, aa0, done0, ill0;
  logic pcw1, irw1, iord1, mrd1, mwr1, rw1, ext1, src1, aa1, done1, ill1;
  logic [3:0] alu0, alu1;
  logic [1:0] npc0, gpr0, wd0, npc1, gpr1, wd1;

  int   total = 0, bad = 0;
  obs_t trace[$];
  logic [2:0] exp_st[$];
  int   exp_pcw, exp_rw, exp_mrd, exp_mwr;
  ent_t tbl[16];

  always #5 clk = ~clk;

  mc_ctrl #(.ILLEGAL_TRAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw0), .IRWrite(irw0), .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0),
    .RegWrite(rw0), .EXTOp(ext0), .ALUOp(alu0), .NPCOp(npc0), .ALUSrc(src0),
    .AASel(aa0), .GPRSel(gpr0), .WDSel(wd0), .instr_done(done0), .illegal(ill0), .state(st0));

  mc_ctrl #(.ILLEGAL_TRAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw1), .IRWrite(irw1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .RegWrite(rw1), .EXTOp(ext1), .ALUOp(alu1), .NPCOp(npc1), .ALUSrc(src1),
    .AASel(aa1), .GPRSel(gpr1), .WDSel(wd1), .instr_done(done1), .illegal(ill1), .state(st1));

  wire [20:0] outs0 = {pcw0, irw0, iord0, mrd0, mwr0, rw0, ext0, alu0, npc0, src0, aa0, gpr0, wd0, done0, ill0};
  wire [20:0] outs1 = {pcw1, irw1, iord1, mrd1, mwr1, rw1, ext1, alu1, npc1, src1, aa1, gpr1, wd1, done1, ill1};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic init_table();
    tbl[0]  = '{"addu", 6'h00, 6'h21, K_R,   4'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{"subu", 6'h00, 6'h23, K_R,   4'd2, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{"and",  6'h00, 6'h24, K_R,   4'd3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{"or",   6'h00, 6'h25, K_R,   4'd4, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{"slt",  6'h00, 6'h2A, K_R,   4'd5, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{"sll",  6'h00, 6'h00, K_R,   4'd6, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{"srl",  6'h00, 6'h02, K_R,   4'd7, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{"jr",   6'h00, 6'h08, K_JR,  4'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{"addi", 6'h08, 6'h00, K_I,   4'd1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{"ori",  6'h0D, 6'h00, K_I,   4'd4, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{"lui",  6'h0F, 6'h00, K_I,   4'd8, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{"lw",   6'h23, 6'h00, K_LW,  4'd1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{"sw",   6'h2B, 6'h00, K_SW,  4'd1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{"beq",  6'h04, 6'h00, K_BEQ, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{"j",    6'h02, 6'h00, K_J,   4'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{"jal",  6'h03, 6'h00, K_JAL, 4'd0, 1'b0, 1'b0, 1'b0};
  endtask

  // Reference: state trace and write counts from per-class cycle rules
  task automatic build_model(input int kind, input int fw, input int mw, input logic z);
    exp_st.delete();
    for (int i = 0; i <= fw; i++) exp_st.push_back(3'd0);
    exp_st.push_back(3'd1);
    if (kind != K_J && kind != K_JAL) exp_st.push_back(3'd2);
    if (kind == K_LW || kind == K_SW) for (int i = 0; i <= mw; i++) exp_st.push_back(3'd3);
    if (kind == K_R || kind == K_I || kind == K_LW) exp_st.push_back(3'd4);
    exp_pcw = 1 + ((kind == K_J || kind == K_JAL || kind == K_JR) ? 1 : 0) + ((kind == K_BEQ && z) ? 1 : 0);
    exp_rw  = (kind == K_R || kind == K_I || kind == K_LW || kind == K_JAL) ? 1 : 0;
    exp_mrd = fw + 1 + ((kind == K_LW) ? mw + 1 : 0);
    exp_mwr = (kind == K_SW) ? mw + 1 : 0;
  endtask

  // Runs one instruction from FETCH; memory stalls fw cycles in FETCH, mw in MEM
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int f, m;
    obs_t o;
    f = fw; m = mw;
    trace.delete();
    Op = op; Funct = fn; Zero = z;
    for (int c = 0; c < 40; c++) begin
      if (st0 == 3'd0)      begin mem_ready = (f == 0); if (f > 0) f--; end
      else if (st0 == 3'd3) begin mem_ready = (m == 0); if (m > 0) m--; end
      else                  mem_ready = 1'($urandom_range(0, 1));
      #1;
      o = '{st0, pcw0, irw0, iord0, mrd0, mwr0, rw0, ext0, alu0, npc0, src0, aa0, gpr0, wd0, done0, ill0};
      trace.push_back(o);
      @(negedge clk);
      if (o.done || o.ill) return;
    end
    total++; bad++;
    $display("FAIL run_timeout: op=%h fn=%h got no instr_done within 40 cycles, required completion", op, fn);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({st0, outs0} !== 24'd0) begin bad++; $display("FAIL reset_dut0: state/outs=%h required 0", {st0, outs0}); end
    total++;
    if ({st1, outs1} !== 24'd0) begin bad++; $display("FAIL reset_dut1: state/outs=%h required 0", {st1, outs1}); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    total++;
    if ({st0, mrd0, iord0, irw0, pcw0} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      begin bad++; $display("FAIL reset_first_fetch: st=%0d mrd=%b iord=%b irw=%b pcw=%b required st=0 mrd=1 others 0", st0, mrd0, iord0, irw0, pcw0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    int n, mw_hi;
    Op = tbl[12].op; Funct = 6'h00;
    n = 0;
    while (st0 != 3'd3 && n < 10) begin
      mem_ready = (st0 == 3'd0);
      @(negedge clk); n++;
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if ({st0, mwr0, iord0} !== {3'd3, 1'b1, 1'b1}) begin bad++; $display("FAIL sw_mem_reach: st=%0d mwr=%b iord=%b required 3 1 1", st0, mwr0, iord0); end
    rst = 1'b1;
    #1;
    total++;
    if (mwr0 !== 1'b0) begin bad++; $display("FAIL rst_mem_mwr: MemWrite=%b required 0 during rst", mwr0); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (st0 !== 3'd0) begin bad++; $display("FAIL rst_mem_state: state=%0d required 0", st0); end
    mw_hi = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (mwr0) mw_hi++;
    end
    total++;
    if (mw_hi !== 0) begin bad++; $display("FAIL rst_mem_nowrite: MemWrite high %0d cycles required 0", mw_hi); end
    @(negedge clk);
  endtask

  task automatic test_addu();
    run_instr(tbl[0].op, tbl[0].fn, 1'b0, 0, 0);
    total++;
    if ({trace.size(), trace[0].st, trace[1].st, trace[2].st, trace[3].st} !== {32'd4, 3'd0, 3'd1, 3'd2, 3'd4})
      begin bad++; $display("FAIL addu_seq: len=%0d got %0d,%0d,%0d,%0d required 0,1,2,4", trace.size(), trace[0].st, trace[1].st, trace[2].st, trace[3].st); end
    total++;
    if ({trace[3].rw, trace[3].gpr, trace[3].wd, trace[3].alu} !== {1'b1, 2'd0, 2'd0, 4'd1})
      begin bad++; $display("FAIL addu_wb: rw=%b gpr=%0d wd=%0d alu=%0d required 1 0 0 1", trace[3].rw, trace[3].gpr, trace[3].wd, trace[3].alu); end
    total++;
    if ({trace[0].done, trace[1].done, trace[2].done, trace[3].done} !== 4'b0001)
      begin bad++; $display("FAIL addu_done: pattern=%b%b%b%b required 0001", trace[0].done, trace[1].done, trace[2].done, trace[3].done); end
  endtask

  task automatic test_lw_waits();
    int badmem;
    run_instr(tbl[11].op, 6'h15, 1'b0, 2, 3);
    total++;
    if (trace.size() !== 10) begin bad++; $display("FAIL lw_len: cycles=%0d required 10", trace.size()); end
    badmem = 0;
    for (int i = 0; i < trace.size(); i++)
      if (trace[i].st == 3'd3 && (trace[i].mrd !== 1'b1 || trace[i].iord !== 1'b1 || trace[i].mwr !== 1'b0)) badmem++;
    total++;
    if (badmem !== 0) begin bad++; $display("FAIL lw_mem_hold: %0d MEM cycles wrong required 0", badmem); end
    total++;
    if ({trace[$].st, trace[$].rw, trace[$].wd, trace[$].gpr} !== {3'd4, 1'b1, 2'd1, 2'd1})
      begin bad++; $display("FAIL lw_wb: st=%0d rw=%b wd=%0d gpr=%0d required 4 1 1 1", trace[$].st, trace[$].rw, trace[$].wd, trace[$].gpr); end
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      run_instr(tbl[13].op, 6'h2A, 1'(z), 0, 0);
      total++;
      if ({trace.size(), trace[2].st, trace[2].pcw, trace[2].npc, trace[2].alu, trace[2].src, trace[2].done}
          !== {32'd3, 3'd2, 1'(z), 2'd1, 4'd2, 1'b0, 1'b1})
        begin bad++; $display("FAIL beq_z%0d: len=%0d st=%0d pcw=%b npc=%0d alu=%0d src=%b done=%b required 3 2 %0d 1 2 0 1",
                              z, trace.size(), trace[2].st, trace[2].pcw, trace[2].npc, trace[2].alu, trace[2].src, trace[2].done, z); end
    end
  endtask

  task automatic test_jal();
    run_instr(tbl[15].op, 6'h08, 1'b0, 0, 0);
    total++;
    if ({trace.size(), trace[1].st, trace[1].pcw, trace[1].npc, trace[1].rw, trace[1].gpr, trace[1].wd, trace[1].done}
        !== {32'd2, 3'd1, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b1})
      begin bad++; $display("FAIL jal_decode: len=%0d st=%0d pcw=%b npc=%0d rw=%b gpr=%0d wd=%0d done=%b required 2 1 1 2 1 2 2 1",
                            trace.size(), trace[1].st, trace[1].pcw, trace[1].npc, trace[1].rw, trace[1].gpr, trace[1].wd, trace[1].done); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int idx, fw, mw, first_bad, npcw, nrw, nmrd, nmwr, nirw, ndone, nbadmem;
      logic z;
      logic [5:0] fn;
      idx = $urandom_range(0, 15);
      fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      z = 1'($urandom_range(0, 1));
      fn = (tbl[idx].op == 6'h00) ? tbl[idx].fn : 6'($urandom);
      build_model(tbl[idx].kind, fw, mw, z);
      run_instr(tbl[idx].op, fn, z, fw, mw);
      first_bad = -1;
      npcw = 0; nrw = 0; nmrd = 0; nmwr = 0; nirw = 0; ndone = 0; nbadmem = 0;
      for (int i = 0; i < trace.size(); i++) begin
        if (first_bad < 0 && (i >= exp_st.size() || trace[i].st !== exp_st[i])) first_bad = i;
        npcw += int'(trace[i].pcw); nrw += int'(trace[i].rw); nmrd += int'(trace[i].mrd);
        nmwr += int'(trace[i].mwr); nirw += int'(trace[i].irw); ndone += int'(trace[i].done);
        if (trace[i].st == 3'd3 && trace[i].iord !== 1'b1) nbadmem++;
      end
      total++;
      if (trace.size() !== exp_st.size() || first_bad >= 0)
        begin bad++; $display("FAIL rand_seq %s: len=%0d first_bad=%0d required len=%0d", tbl[idx].name, trace.size(), first_bad, exp_st.size()); end
      total++;
      if ({npcw, nrw, nmrd, nmwr, nirw} !== {exp_pcw, exp_rw, exp_mrd, exp_mwr, 32'd1})
        begin bad++; $display("FAIL rand_counts %s: pcw=%0d rw=%0d mrd=%0d mwr=%0d irw=%0d required %0d %0d %0d %0d 1",
                              tbl[idx].name, npcw, nrw, nmrd, nmwr, nirw, exp_pcw, exp_rw, exp_mrd, exp_mwr); end
      total++;
      if (ndone !== 1 || trace[$].done !== 1'b1)
        begin bad++; $display("FAIL rand_done %s: pulses=%0d last=%b required 1 1", tbl[idx].name, ndone, trace[$].done); end
      total++;
      if (nbadmem !== 0) begin bad++; $display("FAIL rand_iord %s: %0d MEM cycles with IorD=0 required 0", tbl[idx].name, nbadmem); end
      if (tbl[idx].kind == K_R || tbl[idx].kind == K_I || tbl[idx].kind == K_LW) begin
        logic [1:0] eg, ew;
        eg = (tbl[idx].kind == K_R) ? 2'd0 : 2'd1;
        ew = (tbl[idx].kind == K_LW) ? 2'd1 : 2'd0;
        total++;
        if ({trace[$].gpr, trace[$].wd, trace[$].alu, trace[$].src, trace[$].aa} !== {eg, ew, tbl[idx].alu, tbl[idx].src, tbl[idx].aa})
          begin bad++; $display("FAIL rand_wb %s: gpr=%0d wd=%0d alu=%0d src=%b aa=%b required %0d %0d %0d %b %b", tbl[idx].name,
                                trace[$].gpr, trace[$].wd, trace[$].alu, trace[$].src, trace[$].aa, eg, ew, tbl[idx].alu, tbl[idx].src, tbl[idx].aa); end
        if (tbl[idx].kind != K_R) begin
          total++;
          if (trace[$].ext !== tbl[idx].ext)
            begin bad++; $display("FAIL rand_ext %s: EXTOp=%b required %b", tbl[idx].name, trace[$].ext, tbl[idx].ext); end
        end
      end
    end
  endtask

  task automatic test_illegal();
    int nbad;
    run_instr(6'h3F, 6'($urandom), 1'b0, 1, 0);
    total++;
    if ({trace.size(), trace[$].st, trace[$].ill, trace[$].done, trace[$].pcw, trace[$].rw} !== {32'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0})
      begin bad++; $display("FAIL ill_op: len=%0d st=%0d ill=%b done=%b pcw=%b rw=%b required 3 1 1 0 0 0",
                            trace.size(), trace[$].st, trace[$].ill, trace[$].done, trace[$].pcw, trace[$].rw); end
    total++;
    if ({st0, st1} !== {3'd0, 3'd7}) begin bad++; $display("FAIL ill_next: st0=%0d st1=%0d required 0 7", st0, st1); end
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); Op = 6'($urandom); Zero = 1'($urandom_range(0, 1));
      #1;
      if (st1 !== 3'd7 || outs1 !== 21'd0) nbad++;
      @(negedge clk);
    end
    total++;
    if (nbad !== 0) begin bad++; $display("FAIL halt_hold: %0d cycles left HALT or drove outputs required 0", nbad); end
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({st0, st1} !== 6'd0) begin bad++; $display("FAIL halt_exit: st0=%0d st1=%0d required 0 0", st0, st1); end
    @(negedge clk);
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    total++;
    if ({trace.size(), trace[$].ill, st0, st1} !== {32'd2, 1'b1, 3'd0, 3'd7})
      begin bad++; $display("FAIL ill_funct: len=%0d ill=%b st0=%0d st1=%0d required 2 1 0 7", trace.size(), trace[$].ill, st0, st1); end
  endtask

  initial begin
    init_table();
    test_reset();
    test_reset_mid_mem();
    test_addu();
    test_lw_waits();
    test_beq();
    test_jal();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mc_ctrl
`default_nettype wire
